// File: rtl/neosd_dat_fifo_if.sv
// neosd data FIFO bundle: host word port, data-FSM word port, status.
// slave = FIFO side, master = host/FSM side.
interface neosd_dat_fifo_if #(
  parameter int DEPTH       = 8,
  parameter int BLOCK_WORDS = 128
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int CW = $clog2(BLOCK_WORDS);

  logic          dir_i;
  logic          flush_i;
  logic          host_wr_i;
  logic [31:0]   host_wdata_i;
  logic          host_rd_i;
  logic [31:0]   host_rdata_o;
  logic          fsm_req_i;
  logic [31:0]   fsm_dat_i;
  logic [31:0]   fsm_dat_o;
  logic          fsm_load_o;
  logic          fsm_ack_o;
  logic          empty_o;
  logic          full_o;
  logic [LW-1:0] level_o;
  logic [CW-1:0] word_cnt_o;
  logic          block_wrap_o;
  logic          ovf_o;
  logic          unf_o;

  modport slave (
    input  dir_i, flush_i,
    input  host_wr_i, host_wdata_i, host_rd_i,
    output host_rdata_o,
    input  fsm_req_i, fsm_dat_i,
    output fsm_dat_o, fsm_load_o, fsm_ack_o,
    output empty_o, full_o, level_o,
    output word_cnt_o, block_wrap_o,
    output ovf_o, unf_o
  );

  modport master (
    output dir_i, flush_i,
    output host_wr_i, host_wdata_i, host_rd_i,
    input  host_rdata_o,
    output fsm_req_i, fsm_dat_i,
    input  fsm_dat_o, fsm_load_o, fsm_ack_o,
    input  empty_o, full_o, level_o,
    input  word_cnt_o, block_wrap_o,
    input  ovf_o, unf_o
  );
endinterface

// File: rtl/neosd_dat_fifo.sv
// neosd data FIFO: word buffer between the host data register
// and the SD data-line FSM, TX load pulses and RX ack handshake.
module neosd_dat_fifo #(
  parameter int DEPTH       = 8,
  parameter int BLOCK_WORDS = 128
) (
  input logic            clk_i,
  input logic            rstn_i,
  neosd_dat_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(BLOCK_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_CAPT,
    S_ACK
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dir_q, dir_d;
  logic          req_q, req_d;
  logic          pend_q, pend_d;
  logic          load_q, load_d;
  logic          ack_q, ack_d;
  logic          wrap_q, wrap_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   fdat_q, fdat_d;

  logic        empty, full, req_rise, trig;
  logic        fsm_pop, fsm_push, bypass, cnt_inc;
  logic        host_push, host_pop;
  logic        push, pop, push_ok, pop_ok;
  logic [31:0] push_data;

  assign empty    = (lvl_q == '0);
  assign full     = (lvl_q == LW'(DEPTH));
  assign req_rise = bus.fsm_req_i & ~req_q;
  assign trig     = req_rise | pend_q;

  // Card-side FSM, FIFO bookkeeping, counters and flags.
  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    rp_d      = rp_q;
    lvl_d     = lvl_q;
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    req_d     = bus.fsm_req_i;
    pend_d    = pend_q;
    load_d    = 1'b0;
    ack_d     = ack_q;
    wrap_d    = 1'b0;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    rdata_d   = rdata_q;
    fdat_d    = fdat_q;
    fsm_pop   = 1'b0;
    fsm_push  = 1'b0;
    bypass    = 1'b0;
    cnt_inc   = 1'b0;
    host_push = 1'b0;
    host_pop  = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    push_ok   = 1'b0;
    pop_ok    = 1'b0;
    push_data = dir_q ? bus.host_wdata_i : bus.fsm_dat_i;

    unique case (state_q)
      S_IDLE: begin
        if (trig) begin
          if (dir_q) begin
            if (!empty) begin
              fsm_pop = 1'b1;
              fdat_d  = mem_q[rp_q];
              state_d = S_LOAD;
            end else if (pend_q && bus.host_wr_i) begin
              // late word goes straight through to the FSM
              bypass  = 1'b1;
              fdat_d  = bus.host_wdata_i;
              state_d = S_LOAD;
            end else begin
              pend_d = 1'b1;
              unf_d  = 1'b1;
            end
          end else begin
            if (!full) begin
              fsm_push = 1'b1;
              state_d  = S_CAPT;
            end else begin
              pend_d = 1'b1;
              unf_d  = 1'b1;
            end
          end
        end
      end
      S_LOAD: begin
        load_d  = 1'b1;
        pend_d  = 1'b0;
        cnt_inc = 1'b1;
        state_d = S_IDLE;
      end
      S_CAPT: begin
        ack_d   = 1'b1;
        pend_d  = 1'b0;
        cnt_inc = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        if (!bus.fsm_req_i) begin
          ack_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    host_push = dir_q & bus.host_wr_i & ~bypass;
    host_pop  = ~dir_q & bus.host_rd_i;
    push      = host_push | fsm_push;
    pop       = host_pop | fsm_pop;
    push_ok   = push & ~full;
    pop_ok    = pop & ~empty;

    if (push && full) ovf_d = 1'b1;
    if (host_pop) begin
      if (empty) begin
        rdata_d = '0;
        ovf_d   = 1'b1;
      end else begin
        rdata_d = mem_q[rp_q];
      end
    end

    wp_d  = wp_q + AW'(push_ok);
    rp_d  = rp_q + AW'(pop_ok);
    lvl_d = lvl_q + LW'(push_ok) - LW'(pop_ok);

    if (cnt_inc) begin
      if (cnt_q == CW'(BLOCK_WORDS - 1)) begin
        cnt_d  = '0;
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // direction only follows dir_i while nothing is buffered
    if (empty && state_q == S_IDLE) dir_d = bus.dir_i;

    if (bus.flush_i) begin
      state_d = S_IDLE;
      wp_d    = '0;
      rp_d    = '0;
      lvl_d   = '0;
      cnt_d   = '0;
      dir_d   = dir_q;
      req_d   = 1'b0;
      pend_d  = 1'b0;
      load_d  = 1'b0;
      ack_d   = 1'b0;
      wrap_d  = 1'b0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      rdata_d = '0;
      fdat_d  = '0;
    end
  end

  // Word storage; no reset needed, pointers gate validity.
  always_ff @(posedge clk_i) begin
    if (push_ok && !bus.flush_i) mem_q[wp_q] <= push_data;
  end

  // State and control registers.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      lvl_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      req_q   <= 1'b0;
      pend_q  <= 1'b0;
      load_q  <= 1'b0;
      ack_q   <= 1'b0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      rdata_q <= '0;
      fdat_q  <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      load_q  <= load_d;
      ack_q   <= ack_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      rdata_q <= rdata_d;
      fdat_q  <= fdat_d;
    end
  end

  assign bus.host_rdata_o = rdata_q;
  assign bus.fsm_dat_o    = fdat_q;
  assign bus.fsm_load_o   = load_q;
  assign bus.fsm_ack_o    = ack_q;
  assign bus.empty_o      = empty;
  assign bus.full_o       = full;
  assign bus.level_o      = lvl_q;
  assign bus.word_cnt_o   = cnt_q;
  assign bus.block_wrap_o = wrap_q;
  assign bus.ovf_o        = ovf_q;
  assign bus.unf_o        = unf_q;
endmodule

// File: tb/tb_neosd_dat_fifo.sv
// Bench for neosd_dat_fifo: queue/timestamp reference model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_neosd_dat_fifo;
  localparam int DEPTH = 8;
  localparam int BW    = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  neosd_dat_fifo_if #(.DEPTH(DEPTH), .BLOCK_WORDS(BW)) bus ();

  neosd_dat_fifo #(.DEPTH(DEPTH), .BLOCK_WORDS(BW)) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // reference model: contents as a queue, card-side
  // completions as absolute edge numbers
  logic [31:0] q[$];
  bit          mdir, pend, unf, ovf, req_prev;
  bit          exp_load, exp_wrap, exp_ack;
  int          cnt, edge_n, load_at, capt_at;
  logic [31:0] exp_fdat, exp_rdata;

  function automatic void model_clear();
    q.delete();
    pend = 0; unf = 0; ovf = 0; req_prev = 0;
    exp_load = 0; exp_wrap = 0; exp_ack = 0;
    cnt = 0; load_at = -1; capt_at = -1;
    exp_fdat = '0; exp_rdata = '0;
  endfunction

  function automatic void count_word();
    cnt = (cnt + 1) % BW;
    exp_wrap = (cnt == 0);
  endfunction

  initial begin
    model_clear();
    mdir = 0;
    edge_n = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        model_clear();
        mdir = 0;
      end else begin : step
        int sz0;
        bit idle0, rise, byp;
        edge_n++;
        sz0   = q.size();
        idle0 = (load_at < 0) && (capt_at < 0) && !exp_ack;
        exp_load = 0;
        exp_wrap = 0;
        byp = 0;
        if (bus.flush_i) begin
          model_clear();
        end else begin
          rise = bus.fsm_req_i && !req_prev;
          if (load_at == edge_n) begin
            exp_load = 1; count_word(); pend = 0; load_at = -1;
          end
          if (capt_at == edge_n) begin
            exp_ack = 1; count_word(); pend = 0; capt_at = -1;
          end else if (exp_ack && !bus.fsm_req_i) begin
            exp_ack = 0;
          end
          if (!mdir && bus.host_rd_i) begin
            if (sz0 == 0) begin
              exp_rdata = '0; ovf = 1;
            end else begin
              exp_rdata = q.pop_front();
            end
          end
          if (idle0 && (rise || pend)) begin
            if (mdir) begin
              if (sz0 > 0) begin
                exp_fdat = q.pop_front(); load_at = edge_n + 1;
              end else if (pend && bus.host_wr_i) begin
                exp_fdat = bus.host_wdata_i; byp = 1;
                load_at = edge_n + 1;
              end else begin
                pend = 1; unf = 1;
              end
            end else begin
              if (sz0 < DEPTH) begin
                q.push_back(bus.fsm_dat_i); capt_at = edge_n + 1;
              end else begin
                pend = 1; unf = 1;
              end
            end
          end
          if (mdir && bus.host_wr_i && !byp) begin
            if (sz0 == DEPTH) ovf = 1;
            else q.push_back(bus.host_wdata_i);
          end
          if (sz0 == 0 && idle0) mdir = bus.dir_i;
          req_prev = bus.fsm_req_i;
        end
      end
    end
  end

  // every-cycle comparison against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("m_level", 32'(bus.level_o), 32'(q.size()));
      chk("m_empty", 32'(bus.empty_o), 32'(q.size() == 0));
      chk("m_full",  32'(bus.full_o),  32'(q.size() == DEPTH));
      chk("m_ovf",   32'(bus.ovf_o),   32'(ovf));
      chk("m_unf",   32'(bus.unf_o),   32'(unf));
      chk("m_load",  32'(bus.fsm_load_o), 32'(exp_load));
      chk("m_ack",   32'(bus.fsm_ack_o),  32'(exp_ack));
      chk("m_wcnt",  32'(bus.word_cnt_o), 32'(cnt));
      chk("m_wrap",  32'(bus.block_wrap_o), 32'(exp_wrap));
      chk("m_fdat",  bus.fsm_dat_o, exp_fdat);
      chk("m_rdata", bus.host_rdata_o, exp_rdata);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: bench exceeded time limit");
    $fatal(1);
  end

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(logic [31:0] w);
    bus.host_wr_i = 1'b1;
    bus.host_wdata_i = w;
    tick();
    bus.host_wr_i = 1'b0;
  endtask

  task automatic pop(output logic [31:0] d);
    bus.host_rd_i = 1'b1;
    tick();
    bus.host_rd_i = 1'b0;
    d = bus.host_rdata_o;
  endtask

  task automatic do_flush();
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    tick();
  endtask

  task automatic tx_req(output int lat, output logic [31:0] dat,
                        output logic wrap);
    bus.fsm_req_i = 1'b1;
    lat = -1; dat = '0; wrap = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (bus.fsm_load_o) begin
        lat = i; dat = bus.fsm_dat_o; wrap = bus.block_wrap_o;
        break;
      end
    end
    bus.fsm_req_i = 1'b0;
    tick(2);
  endtask

  task automatic wait_ack(output bit seen);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.fsm_ack_o) begin
        seen = 1;
        break;
      end
    end
  endtask

  task automatic end_ack();
    bus.fsm_req_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (!bus.fsm_ack_o) break;
    end
    chk("ack_drop", 32'(bus.fsm_ack_o), 32'd0);
    tick();
  endtask

  initial begin
    int          lat;
    logic [31:0] d;
    logic        wr;
    bit          acked;

    bus.dir_i = 1'b1;
    bus.flush_i = 1'b0;
    bus.host_wr_i = 1'b0;
    bus.host_wdata_i = '0;
    bus.host_rd_i = 1'b0;
    bus.fsm_req_i = 1'b0;
    bus.fsm_dat_i = '0;
    tick(3);
    chk("rst_level", 32'(bus.level_o), 32'd0);
    chk("rst_empty", 32'(bus.empty_o), 32'd1);
    chk("rst_full",  32'(bus.full_o), 32'd0);
    chk("rst_load",  32'(bus.fsm_load_o), 32'd0);
    chk("rst_ack",   32'(bus.fsm_ack_o), 32'd0);
    chk("rst_ovf",   32'(bus.ovf_o), 32'd0);
    chk("rst_unf",   32'(bus.unf_o), 32'd0);
    chk("rst_wcnt",  32'(bus.word_cnt_o), 32'd0);
    chk("rst_rdata", bus.host_rdata_o, 32'd0);
    chk("rst_fdat",  bus.fsm_dat_o, 32'd0);
    rstn = 1'b1;
    tick(2);

    // TX basic
    for (int i = 1; i <= 8; i++) push(32'h1111_1111 * i);
    tick();
    chk("tx_full",  32'(bus.full_o), 32'd1);
    chk("tx_level", 32'(bus.level_o), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      tx_req(lat, d, wr);
      chk("tx_lat", 32'(lat), 32'd2);
      chk("tx_word", d, 32'h1111_1111 * i);
    end
    chk("tx_empty", 32'(bus.empty_o), 32'd1);

    // TX underrun, late word bypasses the buffer
    bus.fsm_req_i = 1'b1;
    tick(2);
    chk("unf_set", 32'(bus.unf_o), 32'd1);
    chk("unf_noload", 32'(bus.fsm_load_o), 32'd0);
    bus.fsm_req_i = 1'b0;
    tick();
    bus.host_wr_i = 1'b1;
    bus.host_wdata_i = 32'hCAFE_F00D;
    tick();
    bus.host_wr_i = 1'b0;
    lat = -1;
    if (bus.fsm_load_o) lat = 1;
    else begin
      for (int i = 2; i <= 10; i++) begin
        tick();
        if (bus.fsm_load_o) begin
          lat = i;
          break;
        end
      end
    end
    chk("unf_lat", 32'(lat), 32'd2);
    chk("unf_word", bus.fsm_dat_o, 32'hCAFE_F00D);
    tick(2);

    // block wrap
    do_flush();
    chk("flush_unf", 32'(bus.unf_o), 32'd0);
    for (int i = 0; i < 5; i++) push(32'hB000_0000 + i);
    for (int i = 0; i < 5; i++) begin
      tx_req(lat, d, wr);
      chk("bw_word", d, 32'hB000_0000 + i);
      chk("bw_wrap", 32'(wr), 32'(i == 3));
    end
    chk("bw_wcnt", 32'(bus.word_cnt_o), 32'd1);

    // RX backpressure
    bus.dir_i = 1'b0;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      bus.fsm_dat_i = i;
      bus.fsm_req_i = 1'b1;
      wait_ack(acked);
      chk("rx_ack", 32'(acked), 32'd1);
      end_ack();
    end
    bus.fsm_dat_i = 32'd8;
    bus.fsm_req_i = 1'b1;
    wait_ack(acked);
    chk("rx9_noack", 32'(acked), 32'd0);
    chk("rx9_unf", 32'(bus.unf_o), 32'd1);
    chk("rx9_level", 32'(bus.level_o), 32'd8);
    pop(d);
    chk("rx_pop0", d, 32'd0);
    wait_ack(acked);
    chk("rx9_ack", 32'(acked), 32'd1);
    end_ack();
    chk("rx_level8", 32'(bus.level_o), 32'd8);
    for (int i = 1; i <= 8; i++) begin
      pop(d);
      chk("rx_pop", d, 32'(i));
    end
    pop(d);
    chk("rx_pop_empty", d, 32'd0);
    chk("rx_pop_ovf", 32'(bus.ovf_o), 32'd1);

    // overflow and flush
    bus.dir_i = 1'b1;
    tick(2);
    do_flush();
    for (int i = 0; i < 8; i++) push(32'hA000_0000 + i);
    chk("ov_pre", 32'(bus.ovf_o), 32'd0);
    push(32'hA000_0008);
    chk("ov_ovf", 32'(bus.ovf_o), 32'd1);
    chk("ov_level", 32'(bus.level_o), 32'd8);
    bus.flush_i = 1'b1;
    bus.host_wr_i = 1'b1;
    bus.host_wdata_i = 32'hDEAD_BEEF;
    tick();
    bus.flush_i = 1'b0;
    bus.host_wr_i = 1'b0;
    chk("fl_level", 32'(bus.level_o), 32'd0);
    chk("fl_ovf", 32'(bus.ovf_o), 32'd0);
    tick();
    chk("fl_empty", 32'(bus.empty_o), 32'd1);

    // reset while ack is held
    bus.dir_i = 1'b0;
    tick(2);
    bus.fsm_dat_i = 32'h0000_5A5A;
    bus.fsm_req_i = 1'b1;
    wait_ack(acked);
    chk("rs_ack", 32'(acked), 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("rs_ack_drop", 32'(bus.fsm_ack_o), 32'd0);
    chk("rs_level", 32'(bus.level_o), 32'd0);
    bus.fsm_req_i = 1'b0;
    tick(2);
    rstn = 1'b1;
    tick();
    chk("rs_level_post", 32'(bus.level_o), 32'd0);
    chk("rs_ack_post", 32'(bus.fsm_ack_o), 32'd0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
